if_fetch_unit: RTL and testbench

Instruction-fetch front end that produces the `Instr`/`Addr` pair consumed by the IF/ID pipeline register. It owns the PC, drives a single-outstanding-request instruction-memory handshake, and buffers a returned word while the pipeline holds. It accepts branch/jump redirects and generates the bubble/flush request toward IF/ID. It sits between the instruction memory and IF/ID; `hold` and `redirect` come from the hazard/branch logic in ID.

---
 rtl/if_fetch_unit_if.sv | 26 ++
 rtl/if_fetch_unit.sv | 137 +++++++++++++
 tb/tb_if_fetch_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory handshake bundle for the fetch unit.
//   imem_req   : fetch request (master -> memory)
//   imem_addr  : fetch address, stable while a request waits
//   imem_ready : request accepted, imem_rdata valid this cycle
//   imem_rdata : fetched word
// master = fetch unit side, slave = instruction memory side.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end feeding the IF/ID pipeline register.
// Owns the PC, runs a single-outstanding-request instruction-memory
// handshake, parks a returned word while the pipeline holds and kills
// the in-flight fetch on a branch/jump redirect.
//   clk, rst_n        : clock, asynchronous active-low reset
//   hold              : pipeline stall (same signal as the IF/ID hold)
//   redirect          : taken branch/jump, redirect_pc is the target
//   imem (master)     : instruction-memory request/response bundle
//   Instr, Addr       : instruction and its PC+4 toward IF/ID
//   fetch_bubble      : no valid instruction this cycle (ORed into IF/ID flush)
//   pc                : current fetch PC (debug)
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            Instr,
    output logic [31:0]            Addr,
    output logic                   fetch_bubble,
    output logic [31:0]            pc
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] KILL  = 2'd1;
    localparam logic [1:0] HELD  = 2'd2;

    logic [1:0]  state_q,  state_nxt;
    logic [31:0] pc_q,     pc_nxt;
    logic [31:0] buf_q,    buf_nxt;
    logic [31:0] kill_q,   kill_nxt;

    logic        req;
    logic [31:0] addr;
    logic        deliver;
    logic [31:0] dword;
    logic        bubble;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign target   = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        buf_nxt   = buf_q;
        kill_nxt  = kill_q;
        req       = 1'b0;
        addr      = pc_q;
        deliver   = 1'b0;
        dword     = buf_q;
        bubble    = 1'b1;

        case (state_q)
            FETCH: begin
                req  = 1'b1;
                addr = pc_q;
                if (redirect) begin
                    pc_nxt = target;
                    if (!imem.imem_ready) begin
                        kill_nxt  = pc_q;
                        state_nxt = KILL;
                    end
                end else if (imem.imem_ready && hold) begin
                    buf_nxt   = imem.imem_rdata;
                    state_nxt = HELD;
                    bubble    = 1'b0;
                end else if (imem.imem_ready) begin
                    deliver = 1'b1;
                    dword   = imem.imem_rdata;
                end else begin
                    bubble = ~hold;
                end
            end
            KILL: begin
                // Stale request must still complete; its data is dropped.
                req    = 1'b1;
                addr   = kill_q;
                bubble = ~hold | redirect;
                if (redirect) begin
                    pc_nxt = target;
                end else if (imem.imem_ready) begin
                    state_nxt = FETCH;
                end
            end
            HELD: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = FETCH;
                end else if (!hold) begin
                    deliver   = 1'b1;
                    dword     = buf_q;
                    state_nxt = FETCH;
                end else begin
                    bubble = 1'b0;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase

        if (deliver) begin
            bubble = 1'b0;
            pc_nxt = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
            kill_q  <= '0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            buf_q   <= buf_nxt;
            kill_q  <= kill_nxt;
        end
    end

    // Registers already sit at reset values while rst_n is low, but the
    // FETCH decode would still raise a request; gate outputs directly.
    assign imem.imem_req  = rst_n & req;
    assign imem.imem_addr = addr;
    assign Instr          = (rst_n && deliver) ? dword : NOP;
    assign Addr           = (rst_n && deliver) ? pc_plus4 : '0;
    assign fetch_bubble   = ~rst_n | bubble;
    assign pc             = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [31:0] T_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] Instr;
    logic [31:0] Addr;
    logic        fetch_bubble;
    logic [31:0] pc;
    logic [31:0] mem_key;

    int unsigned tests;
    int unsigned fails;

    if_fetch_unit_if tif ();

    if_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .NOP     (T_NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (tif),
        .Instr       (Instr),
        .Addr        (Addr),
        .fetch_bubble(fetch_bubble),
        .pc          (pc)
    );

    // Memory returns a keyed function of the address.
    assign tif.imem_rdata = tif.imem_addr ^ mem_key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        hold;
        logic        redirect;
        logic [31:0] rpc;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] nxt;
        logic        bub;
        logic [31:0] pc;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic h, input logic r, input logic [31:0] rpc,
                           input logic rdy, input logic e_req, input logic [31:0] e_addr,
                           input logic [31:0] e_instr, input logic [31:0] e_nxt,
                           input logic e_bub, input logic [31:0] e_pc);
        vec_t v;
        v.hold = h; v.redirect = r; v.rpc = rpc; v.ready = rdy;
        v.req = e_req; v.addr = e_addr; v.instr = e_instr; v.nxt = e_nxt;
        v.bub = e_bub; v.pc = e_pc;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic e_req, input logic [31:0] e_addr,
                         input logic [31:0] e_instr, input logic [31:0] e_nxt,
                         input logic e_bub, input logic [31:0] e_pc);
        logic [31:0] a_addr;
        logic [31:0] x_addr;
        a_addr = (tif.imem_req === 1'b1) ? tif.imem_addr : 32'h0;
        x_addr = e_req ? e_addr : 32'h0;
        tests++;
        if (tif.imem_req !== e_req || a_addr !== x_addr || Instr !== e_instr ||
            Addr !== e_nxt || fetch_bubble !== e_bub || pc !== e_pc) begin
            fails++;
            $display("FAIL %s: got req=%0b addr=%h Instr=%h Addr=%h bubble=%0b pc=%h, expected req=%0b addr=%h Instr=%h Addr=%h bubble=%0b pc=%h",
                     name, tif.imem_req, a_addr, Instr, Addr, fetch_bubble, pc,
                     e_req, x_addr, e_instr, e_nxt, e_bub, e_pc);
        end
    endtask

    task automatic drive(input logic h, input logic r, input logic [31:0] rpc, input logic rdy);
        hold = h; redirect = r; redirect_pc = rpc; tif.imem_ready = rdy;
    endtask

    // Behavioural reference: a PC, a queue for a parked word and a queue
    // for a killed request that still has to drain.
    logic [31:0] m_pc;
    logic [31:0] m_held[$];
    logic [31:0] m_stale[$];

    initial begin
        tests = 0;
        fails = 0;
        mem_key = 32'h0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset state
        @(negedge clk);
        #1;
        check("reset_state", 1'b0, 32'h0, T_NOP, 32'h0, 1'b1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // wait states at pc=0
        add_vec(0,0,32'h0,0, 1,32'h0,T_NOP,32'h0,1,32'h0);
        add_vec(0,0,32'h0,0, 1,32'h0,T_NOP,32'h0,1,32'h0);
        add_vec(0,0,32'h0,1, 1,32'h0,32'h0,32'h4,0,32'h0);
        // zero-wait stream
        add_vec(0,0,32'h0,1, 1,32'h4,32'h4,32'h8,0,32'h4);
        // hold capture of word @0x8 for three cycles, then release
        add_vec(1,0,32'h0,1, 1,32'h8,T_NOP,32'h0,0,32'h8);
        add_vec(1,0,32'h0,0, 0,32'h0,T_NOP,32'h0,0,32'h8);
        add_vec(1,0,32'h0,0, 0,32'h0,T_NOP,32'h0,0,32'h8);
        add_vec(0,0,32'h0,0, 0,32'h0,32'h8,32'hC,0,32'h8);
        add_vec(0,0,32'h0,1, 1,32'hC,32'hC,32'h10,0,32'hC);
        // redirect while 0x10 pending, stale ready two cycles later
        add_vec(0,1,32'h100,0, 1,32'h10,T_NOP,32'h0,1,32'h10);
        add_vec(0,0,32'h0,0,   1,32'h10,T_NOP,32'h0,1,32'h100);
        add_vec(0,0,32'h0,1,   1,32'h10,T_NOP,32'h0,1,32'h100);
        add_vec(0,0,32'h0,1,   1,32'h100,32'h100,32'h104,0,32'h100);
        // redirect+hold in HELD, unaligned target
        add_vec(1,0,32'h0,1,   1,32'h104,T_NOP,32'h0,0,32'h104);
        add_vec(1,1,32'h203,0, 0,32'h0,T_NOP,32'h0,1,32'h104);
        add_vec(0,0,32'h0,1,   1,32'h200,32'h200,32'h204,0,32'h200);
        // zero-wait redirect to top of memory, PC+4 wraps
        add_vec(0,1,32'hFFFF_FFFC,1, 1,32'h204,T_NOP,32'h0,1,32'h204);
        add_vec(0,0,32'h0,1, 1,32'hFFFF_FFFC,32'hFFFF_FFFC,32'h0,0,32'hFFFF_FFFC);
        add_vec(0,0,32'h0,1, 1,32'h0,32'h0,32'h4,0,32'h0);
        // hold with no data pending in FETCH
        add_vec(1,0,32'h0,0, 1,32'h4,T_NOP,32'h0,0,32'h4);
        // KILL under hold
        add_vec(1,1,32'h40,0, 1,32'h4,T_NOP,32'h0,1,32'h4);
        add_vec(1,0,32'h0,0,  1,32'h4,T_NOP,32'h0,0,32'h40);
        add_vec(0,0,32'h0,1,  1,32'h4,T_NOP,32'h0,1,32'h40);
        add_vec(0,0,32'h0,1,  1,32'h40,32'h40,32'h44,0,32'h40);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].hold, vq[i].redirect, vq[i].rpc, vq[i].ready);
            #2;
            check($sformatf("vec%0d", i), vq[i].req, vq[i].addr, vq[i].instr,
                  vq[i].nxt, vq[i].bub, vq[i].pc);
            @(negedge clk);
        end

        // Reset pulse while in KILL
        drive(0, 1, 32'h80, 0);
        #2;
        check("enter_kill", 1'b1, 32'h44, T_NOP, 32'h0, 1'b1, 32'h44);
        @(negedge clk);
        drive(0, 1, 32'h80, 1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_kill", 1'b0, 32'h0, T_NOP, 32'h0, 1'b1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 32'h0, 0);
        #2;
        check("first_req_after_reset", 1'b1, 32'h0, T_NOP, 32'h0, 1'b1, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 1);
        #2;
        check("deliver_after_reset", 1'b1, 32'h0, 32'h0, 32'h4, 1'b0, 32'h0);
        @(negedge clk);

        // Randomized run against the reference model
        mem_key = 32'h5A5A_1234;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'h0;
        m_held.delete();
        m_stale.delete();
        for (int n = 0; n < 3000; n++) begin
            logic h, r, rdy;
            logic [31:0] rpc, tgt, word;
            logic e_req, e_bub, delivered, parked, draining;
            logic [31:0] e_addr;
            h   = ($urandom_range(0, 99) < 30);
            r   = ($urandom_range(0, 99) < 10);
            rdy = ($urandom_range(0, 99) < 60);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            tgt = {rpc[31:2], 2'b00};
            drive(h, r, rpc, rdy);

            parked    = (m_held.size() != 0);
            draining  = (m_stale.size() != 0);
            delivered = 1'b0;
            word      = 32'h0;
            e_addr    = 32'h0;
            e_bub     = 1'b1;
            if (parked) begin
                e_req = 1'b0;
                if (r)       e_bub = 1'b1;
                else if (!h) begin delivered = 1'b1; word = m_held[0]; end
                else         e_bub = 1'b0;
            end else if (draining) begin
                e_req  = 1'b1;
                e_addr = m_stale[0];
                e_bub  = !h || r;
            end else begin
                e_req  = 1'b1;
                e_addr = m_pc;
                if (r)             e_bub = 1'b1;
                else if (rdy && h) e_bub = 1'b0;
                else if (rdy)      begin delivered = 1'b1; word = m_pc ^ mem_key; end
                else               e_bub = !h;
            end
            if (delivered) e_bub = 1'b0;

            #2;
            check($sformatf("rand%0d", n), e_req, e_addr,
                  delivered ? word : T_NOP, delivered ? m_pc + 32'd4 : 32'h0,
                  e_bub, m_pc);

            @(posedge clk);
            if (parked) begin
                if (r || !h) void'(m_held.pop_front());
            end else if (draining) begin
                if (!r && rdy) void'(m_stale.pop_front());
            end else begin
                if (r && !rdy)       m_stale.push_back(m_pc);
                else if (!r && rdy && h) m_held.push_back(m_pc ^ mem_key);
            end
            if (r)              m_pc = tgt;
            else if (delivered) m_pc = m_pc + 32'd4;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
